// File: rtl/ddr_iod_lane_trainer_pkg.sv
// Shared lane-state encoding and default parameter values for the IOD lane trainer.
package ddr_iod_pkg;

  localparam int DEF_NUM_LANES  = 1;
  localparam int DEF_DLY_W      = 8;
  localparam int DEF_MAX_TAPS   = 255;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_LOCK_CNT   = 4;
  localparam int DEF_MAX_MOVES  = 512;

  typedef enum logic [2:0] {
    LS_IDLE,
    LS_LOAD,
    LS_CLEAR,
    LS_SETTLE,
    LS_SAMPLE,
    LS_MOVE,
    LS_LOCKED,
    LS_FAIL
  } lane_state_e;

endpackage

// File: rtl/ddr_iod_lane_trainer_if.sv
// Control/status bundle between the lane trainer and its IOD lanes plus the requester.
interface ddr_iod_lane_trainer_if import ddr_iod_pkg::*; #(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int DLY_W     = DEF_DLY_W
);
  logic                       START;
  logic [NUM_LANES-1:0]       LANE_MASK;
  logic [NUM_LANES-1:0]       EYE_MONITOR_EARLY;
  logic [NUM_LANES-1:0]       EYE_MONITOR_LATE;
  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE;
  logic [NUM_LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS;
  logic [NUM_LANES-1:0]       DELAY_LINE_LOAD;
  logic [NUM_LANES-1:0]       DELAY_LINE_MOVE;
  logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION;
  logic [NUM_LANES*DLY_W-1:0] TAP_CNT;
  logic [NUM_LANES-1:0]       LANE_LOCKED;
  logic [NUM_LANES-1:0]       LANE_FAIL;
  logic                       BUSY;
  logic                       DONE;

  modport master (
    output START, LANE_MASK, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
    input  EYE_MONITOR_CLEAR_FLAGS, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
           TAP_CNT, LANE_LOCKED, LANE_FAIL, BUSY, DONE
  );

  modport slave (
    input  START, LANE_MASK, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
    output EYE_MONITOR_CLEAR_FLAGS, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
           TAP_CNT, LANE_LOCKED, LANE_FAIL, BUSY, DONE
  );

endinterface

// File: rtl/ddr_iod_lane_ctl.sv
// One lane's training loop: load, clear flags, settle, sample, step the delay line, lock or fail.
module ddr_iod_lane_ctl import ddr_iod_pkg::*; #(
  parameter int DLY_W      = DEF_DLY_W,
  parameter int MAX_TAPS   = DEF_MAX_TAPS,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int MAX_MOVES  = DEF_MAX_MOVES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             lane_en,
  input  logic             early,
  input  logic             late,
  input  logic             out_of_range,
  output logic             clear_flags,
  output logic             load,
  output logic             move,
  output logic             direction,
  output logic             locked,
  output logic             fail,
  output logic [DLY_W-1:0] tap_cnt
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int CLN_W = $clog2(LOCK_CNT + 1);
  localparam int MV_W  = $clog2(MAX_MOVES + 1);

  lane_state_e      state_q, state_d;
  logic [SET_W-1:0] settle_q;
  logic [CLN_W-1:0] clean_q, clean_d;
  logic [MV_W-1:0]  moves_q;
  logic             dir_d;
  logic             restart;
  logic             refuse;

  // Next-state decode; a start is only honoured from a resting state.
  always_comb begin
    state_d = state_q;
    clean_d = clean_q;
    dir_d   = direction;
    restart = 1'b0;
    refuse  = 1'b0;
    case (state_q)
      LS_IDLE, LS_LOCKED, LS_FAIL: begin
        if (start) begin
          restart = 1'b1;
          state_d = lane_en ? LS_LOAD : LS_IDLE;
        end
      end
      LS_LOAD:   state_d = LS_CLEAR;
      LS_CLEAR:  state_d = LS_SETTLE;
      LS_SETTLE: if (settle_q == SET_W'(SETTLE_CYC - 1)) state_d = LS_SAMPLE;
      LS_SAMPLE: begin
        if (early ^ late) begin
          // early-only asks for more delay; refuse when the line or budget is exhausted
          clean_d = '0;
          refuse  = out_of_range
                 || (early && (tap_cnt == DLY_W'(MAX_TAPS)))
                 || (!early && (tap_cnt == '0))
                 || (moves_q == MV_W'(MAX_MOVES));
          if (refuse) begin
            state_d = LS_FAIL;
          end else begin
            state_d = LS_MOVE;
            dir_d   = early;
          end
        end else if (early && late) begin
          clean_d = '0;
          state_d = LS_CLEAR;
        end else begin
          clean_d = clean_q + 1'b1;
          state_d = (clean_q == CLN_W'(LOCK_CNT - 1)) ? LS_LOCKED : LS_CLEAR;
        end
      end
      LS_MOVE:   state_d = LS_CLEAR;
      default:   state_d = LS_IDLE;
    endcase
  end

  // State, counters and registered pulse outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LS_IDLE;
      settle_q    <= '0;
      clean_q     <= '0;
      moves_q     <= '0;
      tap_cnt     <= '0;
      direction   <= 1'b0;
      load        <= 1'b0;
      clear_flags <= 1'b0;
      move        <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q     <= state_d;
      clean_q     <= clean_d;
      direction   <= dir_d;
      settle_q    <= (state_q == LS_SETTLE) ? settle_q + 1'b1 : '0;
      load        <= (state_d == LS_LOAD);
      clear_flags <= (state_d == LS_CLEAR);
      move        <= (state_d == LS_MOVE);
      locked      <= (state_d == LS_LOCKED);
      fail        <= (state_d == LS_FAIL);
      if (restart) begin
        tap_cnt   <= '0;
        moves_q   <= '0;
        clean_q   <= '0;
        direction <= 1'b0;
      end else if (state_d == LS_MOVE) begin
        tap_cnt <= dir_d ? tap_cnt + 1'b1 : tap_cnt - 1'b1;
        moves_q <= moves_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_iod_lane_trainer.sv
// Trains NUM_LANES IOD lanes in parallel; top level only arbitrates START and reports BUSY/DONE.
module ddr_iod_lane_trainer import ddr_iod_pkg::*; #(
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int DLY_W      = DEF_DLY_W,
  parameter int MAX_TAPS   = DEF_MAX_TAPS,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int MAX_MOVES  = DEF_MAX_MOVES
) (
  input  logic                   FAB_CLK,
  input  logic                   RST_N,
  ddr_iod_lane_trainer_if.slave  bus
);

  logic                       busy_q, done_q;
  logic                       start_acc;
  logic                       all_done;
  logic [NUM_LANES-1:0]       mask_q;
  logic [NUM_LANES-1:0]       clear_v, load_v, move_v, dir_v, locked_v, fail_v;
  logic [NUM_LANES*DLY_W-1:0] tap_v;

  assign start_acc = bus.START & ~busy_q;
  assign all_done  = &(locked_v | fail_v | ~mask_q);

  // Accept START only when idle; finish once every trained lane has settled in LOCKED or FAIL.
  always_ff @(posedge FAB_CLK) begin
    if (!RST_N) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mask_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_acc) begin
        busy_q <= 1'b1;
        mask_q <= bus.LANE_MASK;
      end else if (busy_q && all_done) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ddr_iod_lane_ctl #(
      .DLY_W      (DLY_W),
      .MAX_TAPS   (MAX_TAPS),
      .SETTLE_CYC (SETTLE_CYC),
      .LOCK_CNT   (LOCK_CNT),
      .MAX_MOVES  (MAX_MOVES)
    ) u_ctl (
      .clk          (FAB_CLK),
      .rst_n        (RST_N),
      .start        (start_acc),
      .lane_en      (bus.LANE_MASK[i]),
      .early        (bus.EYE_MONITOR_EARLY[i]),
      .late         (bus.EYE_MONITOR_LATE[i]),
      .out_of_range (bus.DELAY_LINE_OUT_OF_RANGE[i]),
      .clear_flags  (clear_v[i]),
      .load         (load_v[i]),
      .move         (move_v[i]),
      .direction    (dir_v[i]),
      .locked       (locked_v[i]),
      .fail         (fail_v[i]),
      .tap_cnt      (tap_v[i*DLY_W +: DLY_W])
    );
  end

  assign bus.EYE_MONITOR_CLEAR_FLAGS = clear_v;
  assign bus.DELAY_LINE_LOAD         = load_v;
  assign bus.DELAY_LINE_MOVE         = move_v;
  assign bus.DELAY_LINE_DIRECTION    = dir_v;
  assign bus.TAP_CNT                 = tap_v;
  assign bus.LANE_LOCKED             = locked_v;
  assign bus.LANE_FAIL               = fail_v;
  assign bus.BUSY                    = busy_q;
  assign bus.DONE                    = done_q;

endmodule
